// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline sequencing bus between the branch/hazard controller and the IF/ID/EX stages.
// master: controller view (consumes stage info, drives PC / IF-ID / flush controls).
// slave : pipeline view (drives stage info, consumes the controls).
interface branch_hazard_ctrl_if #(
  parameter int XLEN = 32
);
  // IF-stage prediction request / response
  logic [XLEN-1:0] if_pc;
  logic            if_is_branch;
  logic [XLEN-1:0] if_br_target;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;

  // ID-stage sources and EX-stage load destination for load-use detection
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_ex_mem_read;
  logic [4:0]      id_ex_rd;

  // EX-stage branch resolution
  logic            ex_br_valid;
  logic [XLEN-1:0] ex_br_pc;
  logic            ex_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_target;

  // Pipeline sequencing controls
  logic            pc_write;
  logic            if_id_write;
  logic            if_flush;
  logic            id_ex_flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  if_pc, if_is_branch, if_br_target,
    input  id_rs1, id_rs2, id_ex_mem_read, id_ex_rd,
    input  ex_br_valid, ex_br_pc, ex_taken, ex_pred_taken, ex_target,
    output pred_taken, pred_pc,
    output pc_write, if_id_write, if_flush, id_ex_flush, redirect_valid, redirect_pc
  );

  modport slave (
    output if_pc, if_is_branch, if_br_target,
    output id_rs1, id_rs2, id_ex_mem_read, id_ex_rd,
    output ex_br_valid, ex_br_pc, ex_taken, ex_pred_taken, ex_target,
    input  pred_taken, pred_pc,
    input  pc_write, if_id_write, if_flush, id_ex_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch prediction (2-bit saturating BHT) and hazard sequencing for the PC and IF/ID register.
// Ports: clk, reset (sync, active-high), bus (branch_hazard_ctrl_if.master: IF predict,
//   ID/EX load-use inputs, EX resolve inputs, pc_write/if_id_write/flush/redirect outputs).
// Optional macro BP_STATS_EN adds stat_branches / stat_mispredicts counters (32-bit, wrapping).
module branch_hazard_ctrl #(
  parameter int BHT_IDX_W = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_hazard_ctrl_if.master bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0] bht [BHT_ENTRIES];

  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 mispredict;
  logic                 load_use;

  logic            pc_write_c;
  logic            if_id_write_c;
  logic            if_flush_c;
  logic            id_ex_flush_c;
  logic            redirect_valid_c;
  logic [XLEN-1:0] redirect_pc_c;

  // Word-aligned PCs: drop the two byte-offset bits before indexing.
  assign if_idx = bus.if_pc[BHT_IDX_W+1:2];
  assign ex_idx = bus.ex_br_pc[BHT_IDX_W+1:2];

  // Prediction reads the array directly, so an update in the same cycle is not visible yet.
  assign bus.pred_taken = bus.if_is_branch & bht[if_idx][1];
  assign bus.pred_pc    = bus.pred_taken ? bus.if_br_target : (bus.if_pc + XLEN'(4));

  assign mispredict = bus.ex_br_valid & (bus.ex_taken != bus.ex_pred_taken);
  assign load_use   = bus.id_ex_mem_read & (bus.id_ex_rd != 5'd0) &
                      ((bus.id_ex_rd == bus.id_rs1) | (bus.id_ex_rd == bus.id_rs2));

  // BHT update: saturating counter per entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (bus.ex_br_valid) begin
      if (bus.ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = RUN;
    pc_write_c       = 1'b1;
    if_id_write_c    = 1'b1;
    if_flush_c       = 1'b0;
    id_ex_flush_c    = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = bus.ex_taken ? bus.ex_target : (bus.ex_br_pc + XLEN'(4));
    if (reset) begin
      state_nxt = RUN;
    end else if (mispredict) begin
      // Squash both younger stages and restart fetch at the resolved PC.
      redirect_valid_c = 1'b1;
      if_flush_c       = 1'b1;
      id_ex_flush_c    = 1'b1;
      state_nxt        = REDIRECT;
    end else if (load_use && (state != REDIRECT)) begin
      // IF/ID holds a bubble right after a redirect, so its register fields are stale there.
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      id_ex_flush_c = 1'b1;
      state_nxt     = STALL;
    end
  end

  assign bus.pc_write       = pc_write_c;
  assign bus.if_id_write    = if_id_write_c;
  assign bus.if_flush       = if_flush_c;
  assign bus.id_ex_flush    = id_ex_flush_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (bus.ex_br_valid) stat_branches    <= stat_branches + 32'd1;
      if (mispredict)      stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench for branch_hazard_ctrl: BHT reset/update/saturation, mispredict
// redirect, load-use stall, priorities and reset recovery; stats checked when BP_STATS_EN is set.
module tb_branch_hazard_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  branch_hazard_ctrl_if #(.XLEN(32)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_hazard_ctrl #(.BHT_IDX_W(6), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_pc = 32'h0; bus.if_is_branch = 1'b0; bus.if_br_target = 32'h0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_ex_mem_read = 1'b0; bus.id_ex_rd = 5'd0;
    bus.ex_br_valid = 1'b0; bus.ex_br_pc = 32'h0; bus.ex_taken = 1'b0;
    bus.ex_pred_taken = 1'b0; bus.ex_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    tests++;
    if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1 || bus.if_flush !== 1'b0 ||
        bus.id_ex_flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got pcw=%b ifidw=%b iff=%b idexf=%b rv=%b, want 1 1 0 0 0",
               bus.pc_write, bus.if_id_write, bus.if_flush, bus.id_ex_flush, bus.redirect_valid);
    end
    reset = 1'b0;
    bus.if_is_branch = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.if_pc = i * 4;
      #1;
      tests++;
      if (bus.pred_taken !== 1'b0) begin
        fails++;
        $display("FAIL reset_bht idx=%0d: pred_taken=%b want 0", i, bus.pred_taken);
      end
    end
    bus.if_pc = 32'h10; bus.if_br_target = 32'h900;
    #1;
    tests++;
    if (bus.pred_pc !== 32'h14) begin
      fails++;
      $display("FAIL reset_pred_pc: got %h want 00000014", bus.pred_pc);
    end
    tick();
  endtask

  task automatic test_bht_update();
    logic outcome  [8];
    logic exp_pred [8];
    // 01 -> 10 -> 11 -> 11(sat) -> 10 -> 01 -> 00 -> 00(sat) -> 01
    outcome  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    bus.if_pc = 32'h40; bus.if_is_branch = 1'b1; bus.if_br_target = 32'h1234;
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h40;
    bus.ex_taken = 1'b1; bus.ex_pred_taken = 1'b1;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL bht_no_bypass: pred_taken=%b want 0", bus.pred_taken);
    end
    for (int k = 0; k < 8; k++) begin
      bus.ex_taken = outcome[k]; bus.ex_pred_taken = outcome[k];
      tick();
      tests++;
      if (bus.pred_taken !== exp_pred[k]) begin
        fails++;
        $display("FAIL bht_step%0d: pred_taken=%b want %b", k, bus.pred_taken, exp_pred[k]);
      end
    end
    // Entry now 01; one more taken -> 10 (predict taken).
    bus.ex_taken = 1'b1; bus.ex_pred_taken = 1'b1;
    tick();
    bus.ex_br_valid = 1'b0;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b1 || bus.pred_pc !== 32'h1234) begin
      fails++;
      $display("FAIL bht_pred_pc: pred=%b pc=%h want 1 00001234", bus.pred_taken, bus.pred_pc);
    end
    bus.if_is_branch = 1'b0;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0 || bus.pred_pc !== 32'h44) begin
      fails++;
      $display("FAIL bht_not_branch: pred=%b pc=%h want 0 00000044", bus.pred_taken, bus.pred_pc);
    end
    bus.if_is_branch = 1'b1; bus.if_pc = 32'h44;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL bht_neighbour: pred_taken=%b want 0", bus.pred_taken);
    end
    tick();
  endtask

  task automatic test_mispredict();
    idle_inputs();
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h100;
    bus.ex_pred_taken = 1'b0; bus.ex_taken = 1'b1; bus.ex_target = 32'h200;
    #1;
    tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200 || bus.if_flush !== 1'b1 ||
        bus.id_ex_flush !== 1'b1 || bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin
      fails++;
      $display("FAIL mispredict_taken: rv=%b rpc=%h iff=%b idexf=%b pcw=%b want 1 00000200 1 1 1",
               bus.redirect_valid, bus.redirect_pc, bus.if_flush, bus.id_ex_flush, bus.pc_write);
    end
    tick();
    // REDIRECT: load-use must be ignored.
    bus.ex_br_valid = 1'b0;
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5; bus.id_rs2 = 5'd5;
    #1;
    tests++;
    if (bus.pc_write !== 1'b1 || bus.id_ex_flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_state: pcw=%b idexf=%b rv=%b want 1 0 0",
               bus.pc_write, bus.id_ex_flush, bus.redirect_valid);
    end
    tick();
    // Back in RUN: the same load-use now stalls.
    tests++;
    if (bus.pc_write !== 1'b0 || bus.id_ex_flush !== 1'b1) begin
      fails++;
      $display("FAIL redirect_to_run: pcw=%b idexf=%b want 0 1", bus.pc_write, bus.id_ex_flush);
    end
    idle_inputs();
    tick(); tick();
    // Not-taken mispredict at top of address space wraps to 0.
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'hFFFF_FFFC;
    bus.ex_pred_taken = 1'b1; bus.ex_taken = 1'b0; bus.ex_target = 32'h300;
    #1;
    tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL mispredict_wrap: rv=%b rpc=%h want 1 00000000", bus.redirect_valid, bus.redirect_pc);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs1 = 5'd3;
    #1;
    tests++;
    if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0 || bus.id_ex_flush !== 1'b1 ||
        bus.if_flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_use_stall: pcw=%b ifidw=%b idexf=%b iff=%b rv=%b want 0 0 1 0 0",
               bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.if_flush, bus.redirect_valid);
    end
    tick();
    bus.id_ex_mem_read = 1'b0;
    #1;
    tests++;
    if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1 || bus.id_ex_flush !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: pcw=%b ifidw=%b idexf=%b want 1 1 0",
               bus.pc_write, bus.if_id_write, bus.id_ex_flush);
    end
    tick();
    // rd = x0 never stalls.
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    #1;
    tests++;
    if (bus.pc_write !== 1'b1 || bus.id_ex_flush !== 1'b0) begin
      fails++;
      $display("FAIL load_use_x0: pcw=%b idexf=%b want 1 0", bus.pc_write, bus.id_ex_flush);
    end
    // Matching register but not a load: no stall.
    bus.id_ex_mem_read = 1'b0; bus.id_ex_rd = 5'd7; bus.id_rs1 = 5'd7;
    #1;
    tests++;
    if (bus.pc_write !== 1'b1) begin
      fails++;
      $display("FAIL no_load_no_stall: pcw=%b want 1", bus.pc_write);
    end
    // rs1 match stalls, and a persisting hazard in STALL re-stalls.
    bus.id_ex_mem_read = 1'b1;
    tick();
    tests++;
    if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0 || bus.id_ex_flush !== 1'b1) begin
      fails++;
      $display("FAIL restall: pcw=%b ifidw=%b idexf=%b want 0 0 1",
               bus.pc_write, bus.if_id_write, bus.id_ex_flush);
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd9; bus.id_rs1 = 5'd9;
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h500;
    bus.ex_pred_taken = 1'b1; bus.ex_taken = 1'b0; bus.ex_target = 32'h800;
    #1;
    tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h504 || bus.pc_write !== 1'b1 ||
        bus.if_id_write !== 1'b1) begin
      fails++;
      $display("FAIL mispredict_over_load_use: rv=%b rpc=%h pcw=%b ifidw=%b want 1 00000504 1 1",
               bus.redirect_valid, bus.redirect_pc, bus.pc_write, bus.if_id_write);
    end
    tick();
    idle_inputs();
    tick();
    // Mispredict arriving while in STALL.
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd4; bus.id_rs2 = 5'd4;
    tick();
    bus.id_ex_mem_read = 1'b0;
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h600;
    bus.ex_pred_taken = 1'b0; bus.ex_taken = 1'b1; bus.ex_target = 32'hA00;
    #1;
    tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hA00 || bus.if_flush !== 1'b1) begin
      fails++;
      $display("FAIL mispredict_in_stall: rv=%b rpc=%h iff=%b want 1 00000a00 1",
               bus.redirect_valid, bus.redirect_pc, bus.if_flush);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    // Mispredict during reset: reset wins, no redirect and next state is RUN.
    reset = 1'b1;
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h700;
    bus.ex_pred_taken = 1'b0; bus.ex_taken = 1'b1; bus.ex_target = 32'hB00;
    #1;
    tests++;
    if (bus.redirect_valid !== 1'b0 || bus.if_flush !== 1'b0 || bus.id_ex_flush !== 1'b0) begin
      fails++;
      $display("FAIL reset_over_mispredict: rv=%b iff=%b idexf=%b want 0 0 0",
               bus.redirect_valid, bus.if_flush, bus.id_ex_flush);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd6; bus.id_rs1 = 5'd6;
    #1;
    tests++;
    if (bus.pc_write !== 1'b0 || bus.id_ex_flush !== 1'b1) begin
      fails++;
      $display("FAIL reset_returns_run: pcw=%b idexf=%b want 0 1", bus.pc_write, bus.id_ex_flush);
    end
    idle_inputs();
    // Entries trained earlier (0x40, 0x100->idx0) are back to weakly not-taken.
    bus.if_is_branch = 1'b1; bus.if_pc = 32'h40;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_bht_0x40: pred_taken=%b want 0", bus.pred_taken);
    end
    bus.if_pc = 32'h0;
    #1;
    tests++;
    if (bus.pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_bht_0x0: pred_taken=%b want 0", bus.pred_taken);
    end
    tick();
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      fails++;
      $display("FAIL stats_reset: br=%0d mp=%0d want 0 0", stat_branches, stat_mispredicts);
    end
    for (int k = 0; k < 10; k++) begin
      bus.ex_br_valid = 1'b1; bus.ex_br_pc = 32'h1000 + k * 4;
      bus.ex_taken = 1'b1;
      bus.ex_pred_taken = (k == 2 || k == 5 || k == 8) ? 1'b0 : 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    tests++;
    if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
      fails++;
      $display("FAIL stats_count: br=%0d mp=%0d want 10 3", stat_branches, stat_mispredicts);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      fails++;
      $display("FAIL stats_clear: br=%0d mp=%0d want 0 0", stat_branches, stat_mispredicts);
    end
    tick();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_bht_update();
    test_mispredict();
    test_load_use();
    test_priority();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
